// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter, one decrement per prescaled tick.
// LEDR shows the remaining count; LEDR[9] flags completion.
module countdown_timer #(
  parameter int W        = 9,
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       CLOCK_50,
  input  logic [2:0] KEY,
  input  logic [9:0] SW,
  output logic [9:0] LEDR
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  logic resetn;
  assign resetn = KEY[0];

  // bit 1 = load (KEY[2]), bit 0 = start (KEY[1])
  logic [1:0] key_s1;
  logic [1:0] key_s2;
  logic [1:0] key_d;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      key_s1 <= '1;
      key_s2 <= '1;
      key_d  <= '1;
    end else begin
      key_s1 <= KEY[2:1];
      key_s2 <= key_s1;
      key_d  <= key_s2;
    end
  end

  logic load_p;
  logic start_p;

  assign load_p  = key_d[1] & ~key_s2[1];
  assign start_p = key_d[0] & ~key_s2[0] & ~load_p;

  state_t        state_q;
  state_t        state_d;
  logic [W-1:0]  count_q;
  logic [W-1:0]  count_d;
  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      count_q <= '0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      presc_q <= presc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    presc_d = presc_q;
    unique case (state_q)
      RUN: begin
        if (start_p) begin
          state_d = PAUSE;
        end else if (presc_q == PMAX) begin
          presc_d = '0;
          count_d = count_q - W'(1);
          if (count_q == W'(1) || count_q == '0) begin
            count_d = '0;
            state_d = DONE;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      IDLE: begin
        if (load_p) begin
          count_d = SW[W-1:0];
          presc_d = '0;
        end else if (start_p && count_q != '0) begin
          state_d = RUN;
          presc_d = '0;
        end
      end
      PAUSE: begin
        if (load_p) begin
          count_d = SW[W-1:0];
          presc_d = '0;
          state_d = IDLE;
        end else if (start_p) begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (load_p) begin
          count_d = SW[W-1:0];
          presc_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    LEDR         = '0;
    LEDR[W-1:0]  = count_q;
    LEDR[9]      = (state_q == DONE);
  end

  logic unused_sw;
  assign unused_sw = ^SW;

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed vector table plus random button traffic,
// every cycle compared against a run-cycle-count reference model.
module tb_countdown_timer;

  localparam int TD = 4;

  localparam int OP_PRESS = 0;
  localparam int OP_WAIT  = 1;
  localparam int OP_RSTA  = 2;
  localparam int OP_RSTR  = 3;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       k1   = 1'b1;
  logic       k2   = 1'b1;
  logic [9:0] sw   = '0;
  logic [9:0] ledr;
  logic [2:0] key;

  assign key = {k2, k1, rstn};

  countdown_timer #(
    .W(9),
    .TICK_DIV(TD)
  ) dut (
    .CLOCK_50(clk),
    .KEY(key),
    .SW(sw),
    .LEDR(ledr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int m_mode = M_IDLE;
  int m_n    = 0;
  int m_run  = 0;
  int ev_load[int];
  bit ev_start[int];

  // Reference: count is the loaded value minus completed ticks,
  // where ticks = RUN cycles / TD.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_mode = M_IDLE;
      m_n    = 0;
      m_run  = 0;
      ev_load.delete();
      ev_start.delete();
    end else begin
      bit l;
      bit s;
      int lv;
      cyc++;
      l  = ev_load.exists(cyc);
      s  = ev_start.exists(cyc);
      lv = l ? ev_load[cyc] : 0;
      if (m_mode == M_RUN) begin
        if (s && !l) begin
          m_mode = M_PAUSE;
        end else begin
          m_run++;
          if (m_run == m_n * TD) m_mode = M_DONE;
        end
      end else if (l) begin
        m_mode = M_IDLE;
        m_n    = lv;
        m_run  = 0;
      end else if (s) begin
        if (m_mode == M_IDLE && m_n != 0) begin
          m_mode = M_RUN;
          m_run  = 0;
        end else if (m_mode == M_PAUSE) begin
          m_mode = M_RUN;
        end
      end
    end
  end

  function automatic logic [9:0] m_exp();
    if (m_mode == M_DONE) return 10'h200;
    if (m_mode == M_IDLE) return 10'(m_n);
    return 10'(m_n - m_run / TD);
  endfunction

  always @(negedge clk) begin
    #1;
    checks++;
    if (ledr !== m_exp()) begin
      errors++;
      $display("FAIL model cyc=%0d got=%h want=%h", cyc, ledr, m_exp());
    end
  end

  // Called at a falling edge; the pulse acts on the 3rd rising edge.
  task automatic press(input int mask, input int swv, input int hold);
    sw = 10'(swv);
    if (mask[2]) begin
      k2 = 1'b0;
      ev_load[cyc + 3] = swv & 'h1FF;
    end
    if (mask[1]) begin
      k1 = 1'b0;
      ev_start[cyc + 3] = 1'b1;
    end
    repeat (hold) @(negedge clk);
    k1 = 1'b1;
    k2 = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    int         op;
    int         mask;
    int         sw;
    int         hold;
    int         wt;
    logic [9:0] exp;
  } vec_t;

  vec_t tv[$];

  function automatic void add(input int op, input int mask, input int swv,
                              input int hold, input int wt,
                              input logic [9:0] exp);
    vec_t v;
    v.op   = op;
    v.mask = mask;
    v.sw   = swv;
    v.hold = hold;
    v.wt   = wt;
    v.exp  = exp;
    tv.push_back(v);
  endfunction

  initial begin
    add(OP_RSTA, 0, 0, 0, 0, 10'h000);
    add(OP_RSTR, 0, 0, 0, 2, 10'h000);
    add(OP_PRESS, 4, 5, 1, 0, 10'h005);
    add(OP_PRESS, 2, 5, 1, 0, 10'h005);
    add(OP_WAIT, 0, 0, 0, 3, 10'h004);
    add(OP_WAIT, 0, 0, 0, 15, 10'h001);
    add(OP_WAIT, 0, 0, 0, 1, 10'h200);
    add(OP_PRESS, 4, 5, 1, 0, 10'h005);
    add(OP_PRESS, 2, 5, 1, 7, 10'h003);
    add(OP_PRESS, 2, 5, 100, 0, 10'h003);
    add(OP_WAIT, 0, 0, 0, 20, 10'h003);
    add(OP_PRESS, 2, 5, 1, 8, 10'h001);
    add(OP_WAIT, 0, 0, 0, 1, 10'h200);
    add(OP_PRESS, 4, 5, 1, 0, 10'h005);
    add(OP_PRESS, 2, 5, 1, 0, 10'h005);
    add(OP_PRESS, 4, 9, 1, 0, 10'h004);
    add(OP_WAIT, 0, 0, 0, 15, 10'h200);
    add(OP_PRESS, 6, 3, 1, 0, 10'h003);
    add(OP_WAIT, 0, 0, 0, 8, 10'h003);
    add(OP_RSTA, 0, 0, 0, 0, 10'h000);
    add(OP_RSTR, 0, 0, 0, 2, 10'h000);
    add(OP_PRESS, 2, 5, 50, 0, 10'h000);
    add(OP_PRESS, 4, 6, 1, 0, 10'h006);
    add(OP_PRESS, 2, 6, 10, 0, 10'h004);
    add(OP_WAIT, 0, 0, 0, 14, 10'h200);
    add(OP_PRESS, 4, 7, 1, 0, 10'h007);
    add(OP_PRESS, 2, 7, 1, 0, 10'h007);
    add(OP_RSTA, 0, 0, 0, 0, 10'h000);
    add(OP_RSTR, 0, 0, 0, 4, 10'h000);
    add(OP_PRESS, 2, 7, 1, 0, 10'h000);
    add(OP_PRESS, 4, 1, 1, 0, 10'h001);
    add(OP_PRESS, 2, 1, 1, 3, 10'h200);
    add(OP_PRESS, 2, 1, 1, 5, 10'h200);
    add(OP_PRESS, 4, 1, 1, 0, 10'h001);

    for (int i = 0; i < tv.size(); i++) begin
      vec_t v;
      v = tv[i];
      case (v.op)
        OP_RSTA: begin
          #3 rstn = 1'b0;
          #1;
        end
        OP_RSTR: begin
          rstn = 1'b1;
          repeat (v.wt) @(negedge clk);
        end
        OP_PRESS: begin
          press(v.mask, v.sw, v.hold);
          repeat (v.wt) @(negedge clk);
        end
        default: begin
          repeat (v.wt) @(negedge clk);
        end
      endcase
      checks++;
      if (ledr !== v.exp) begin
        errors++;
        $display("FAIL vec%0d got=%h want=%h", i, ledr, v.exp);
      end
      if (v.op == OP_RSTA) @(negedge clk);
    end

    for (int i = 0; i < 80; i++) begin
      int r;
      int swv;
      r   = $urandom_range(0, 9);
      swv = ($urandom_range(0, 1) << 9) | $urandom_range(0, 12);
      if (r <= 2) begin
        press(4, swv, $urandom_range(1, 8));
      end else if (r <= 5) begin
        press(2, swv, $urandom_range(1, 8));
      end else if (r == 6) begin
        press(6, swv, $urandom_range(1, 8));
      end else if (r <= 8) begin
        repeat ($urandom_range(1, 30)) @(negedge clk);
      end else begin
        #3 rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
      end
    end

    repeat (2) @(negedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
